ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Sits between the PS/2 byte receiver (sync, edge detect, 11-bit frame shifter) and the falling-block object FSM.
- Consumes validated scancode bytes (set 2) and tracks make/break/extended prefixes and per-key held state.
- Emits single-cycle game command pulses: left, right, soft-down, rotate, drop.
- Generates its own auto-repeat for movement keys and ignores keyboard typematic repeats.

Parameters:
REPEAT_DELAY, 12500000, cycles from initial press to first auto-repeat pulse (250 ms at 50 MHz)
REPEAT_RATE, 2500000, cycles between subsequent auto-repeat pulses (50 ms)
PREFIX_TIMEOUT, 100000, cycles allowed between a prefix byte (E0/F0) and the next byte before abandoning the sequence
CW, 24, counter width; must hold max(REPEAT_DELAY, REPEAT_RATE, PREFIX_TIMEOUT)

Ports:
Clock  input  1  system clock (50 MHz)
Reset  input  1  synchronous, active-high reset
byte_valid  input  1  one-cycle strobe: byte_data holds a received, parity-checked scancode byte
byte_data  input  8  scancode byte
cmd_left  output  1  one-cycle pulse: move left
cmd_right  output  1  one-cycle pulse: move right
cmd_down  output  1  one-cycle pulse: soft drop one row
cmd_rotate  output  1  one-cycle pulse: rotate
cmd_drop  output  1  one-cycle pulse: hard drop
key_held  output  5  held flags {drop, rotate, down, right, left}
last_code  output  8  last mapped make code accepted (debug/HEX display)

Behaviour:
- Clock and reset: one clock, Clock. Reset is synchronous and active-high. While Reset is high, all outputs are 0, key_held is 0, the FSM is IDLE and all counters are 0.
- Key map (ext = E0 prefix seen):
  - left = E0 6B; right = E0 74; down = E0 72.
  - rotate = E0 75 (up arrow) or 22 (X).
  - drop = 1A (Z) or 29 (space).
  - All other codes are unmapped. Unmapped codes change no outputs but still return the FSM to IDLE.
- Prefix FSM; transitions occur only on byte_valid:
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte -> make(code, ext=0), stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; other -> make(code, ext=1) -> IDLE.
  - BRK: any byte -> break(code, ext=0) -> IDLE.
  - EXT_BRK: any byte -> break(code, ext=1) -> IDLE.
- Prefix timeout: in EXT, BRK or EXT_BRK, if PREFIX_TIMEOUT cycles elapse with no byte_valid, the FSM returns to IDLE and the pending prefix is discarded. The timeout counter clears on every byte_valid.
- Make handling:
  - Key not held: set key_held bit and pulse its cmd in the cycle after byte_valid (latency 1). last_code updates in the same cycle.
  - Key already held (keyboard typematic): no pulse, no state change.
- Break handling: clear key_held bit; stop that key's repeat timer. Break of a key that is not held is a no-op.
- Auto-repeat (left, right, down only; rotate and drop never repeat):
  - Timer loads at the first make.
  - First repeat pulse fires REPEAT_DELAY cycles after the initial pulse; subsequent pulses every REPEAT_RATE cycles while held.
- Simultaneous events: if a break for a key arrives in the same cycle its repeat timer expires, the break wins and no pulse is emitted.
- Multiple keys: keys are independent. cmd_left and cmd_right may both pulse in the same cycle; downstream arbitrates.
- Pulse width: every cmd output is exactly one cycle wide. No two pulses for the same key occur in consecutive cycles.
- Reset mid-sequence: a prefix in progress is discarded; held keys are forgotten. A later break for a forgotten key is a no-op.

Decomposition:
- Shared package holds:
  - scancode constants (SC_E0, SC_F0, SC_Z, SC_X, SC_SPACE, SC_LEFT, SC_RIGHT, SC_DOWN, SC_UP);
  - prefix FSM state encoding (IDLE, EXT, BRK, EXT_BRK);
  - key index constants (K_LEFT=0, K_RIGHT=1, K_DOWN=2, K_ROT=3, K_DROP=4).
- Sub-module key_repeat_timer: start/stop/held inputs, pulse output, DELAY and RATE parameters. It is instantiated three times, for left, right and down.

Test Plan:
- Reset, then byte 1A -> cmd_drop=1 for exactly one cycle, 1 cycle after byte_valid; key_held[4]=1; last_code=8'h1A.
- With REPEAT_DELAY=20, REPEAT_RATE=5: send E0 6B, then E0 6B again after 3 cycles, hold -> cmd_left pulses at t+1, t+21, t+26, t+31; the second make produces no extra pulse.
- Hold left, then send E0 F0 6B -> key_held[0]=0 and no further cmd_left pulses; break timed to coincide with a repeat expiry -> no pulse that cycle.
- Send F0 1A with no prior make -> no pulse, key_held unchanged; send 1C (unmapped) -> all outputs remain 0.
- With PREFIX_TIMEOUT=50: send E0, wait 60 cycles, send 6B -> treated as non-extended 6B (unmapped), so no cmd_left pulse.
- Hold right with repeat active, assert Reset for 1 cycle mid-sequence after F0 -> all outputs 0 and key_held=0; a subsequent E0 F0 74 is a no-op.

Source files
------------

// File: rtl/ps2_key_decoder_pkg.sv
// PS/2 set-2 scancode decoder: shared constants and types.
// Holds scancodes, prefix FSM states, key indices and the key map.
package ps2_key_decoder_pkg;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_Z     = 8'h1A;
    localparam logic [7:0] SC_X     = 8'h22;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_UP    = 8'h75;

    localparam int K_LEFT  = 0;
    localparam int K_RIGHT = 1;
    localparam int K_DOWN  = 2;
    localparam int K_ROT   = 3;
    localparam int K_DROP  = 4;
    localparam int NKEYS   = 5;

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } state_e;

    // One-hot key select for a code; zero when unmapped.
    function automatic logic [NKEYS-1:0] key_map(
        input logic [7:0] code,
        input logic       ext
    );
        logic [NKEYS-1:0] k;
        k = '0;
        if (ext) begin
            if (code == SC_LEFT)  k[K_LEFT]  = 1'b1;
            if (code == SC_RIGHT) k[K_RIGHT] = 1'b1;
            if (code == SC_DOWN)  k[K_DOWN]  = 1'b1;
            if (code == SC_UP)    k[K_ROT]   = 1'b1;
        end else begin
            if (code == SC_X)     k[K_ROT]   = 1'b1;
            if (code == SC_Z)     k[K_DROP]  = 1'b1;
            if (code == SC_SPACE) k[K_DROP]  = 1'b1;
        end
        return k;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Byte input and command output bundle of the key decoder.
// master = byte source / command consumer, slave = decoder.
interface ps2_key_decoder_if;
    import ps2_key_decoder_pkg::*;

    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             cmd_left;
    logic             cmd_right;
    logic             cmd_down;
    logic             cmd_rotate;
    logic             cmd_drop;
    logic [NKEYS-1:0] key_held;
    logic [7:0]       last_code;

    modport master (
        output byte_valid, byte_data,
        input  cmd_left, cmd_right, cmd_down,
        input  cmd_rotate, cmd_drop,
        input  key_held, last_code
    );

    modport slave (
        input  byte_valid, byte_data,
        output cmd_left, cmd_right, cmd_down,
        output cmd_rotate, cmd_drop,
        output key_held, last_code
    );

endinterface

// File: rtl/ps2_key_decoder_key_repeat_timer.sv
// Auto-repeat timer for one movement key.
// pulse is combinational; the decoder registers it into the cmd output.
module key_repeat_timer #(
    parameter int unsigned CW    = 24,
    parameter int unsigned DELAY = 12500000,
    parameter int unsigned RATE  = 2500000
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic stop,
    input  logic held,
    output logic pulse
);
    localparam logic [CW-1:0] LD_DLY = CW'(DELAY - 1);
    localparam logic [CW-1:0] LD_RPT = CW'(RATE - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          act_q, act_d;
    logic          expire;

    // Countdown: load on start, reload on expiry, clear on stop.
    always_comb begin
        cnt_d  = cnt_q;
        act_d  = act_q;
        expire = act_q && held && (cnt_q == '0);
        pulse  = expire && !stop;
        if (stop) begin
            act_d = 1'b0;
            cnt_d = '0;
        end else if (start) begin
            act_d = 1'b1;
            cnt_d = LD_DLY;
        end else if (!held) begin
            act_d = 1'b0;
            cnt_d = '0;
        end else if (expire) begin
            cnt_d = LD_RPT;
        end else if (act_q) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Timer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            act_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            act_q <= act_d;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// Set-2 scancode to game command decoder with prefix FSM,
// per-key held tracking and auto-repeat for movement keys.
module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY   = 12500000,
    parameter int unsigned REPEAT_RATE    = 2500000,
    parameter int unsigned PREFIX_TIMEOUT = 100000,
    parameter int unsigned CW             = 24
) (
    input  logic         Clock,
    input  logic         Reset,
    ps2_key_decoder_if.slave bus
);
    localparam logic [CW-1:0] TO_LAST = CW'(PREFIX_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    to_cnt_q, to_cnt_d;
    logic [NKEYS-1:0] held_q, held_d;
    logic [NKEYS-1:0] cmd_q, cmd_d;
    logic [7:0]       last_q, last_d;

    logic             is_make, is_brk, ext;
    logic [NKEYS-1:0] hit, make_hit, brk_hit, new_press;
    logic [2:0]       rep_pulse;

    // Prefix FSM, timeout, and make/break to held/cmd update.
    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        is_make  = 1'b0;
        is_brk   = 1'b0;
        ext      = 1'b0;
        if (bus.byte_valid) begin
            to_cnt_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (bus.byte_data == SC_E0) begin
                        state_d = EXT;
                    end else if (bus.byte_data == SC_F0) begin
                        state_d = BRK;
                    end else begin
                        is_make = 1'b1;
                    end
                end
                EXT: begin
                    if (bus.byte_data == SC_F0) begin
                        state_d = EXT_BRK;
                    end else if (bus.byte_data != SC_E0) begin
                        is_make = 1'b1;
                        ext     = 1'b1;
                        state_d = IDLE;
                    end
                end
                BRK: begin
                    is_brk  = 1'b1;
                    state_d = IDLE;
                end
                EXT_BRK: begin
                    is_brk  = 1'b1;
                    ext     = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (to_cnt_q == TO_LAST) begin
                state_d  = IDLE;
                to_cnt_d = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end

        hit       = key_map(bus.byte_data, ext);
        make_hit  = is_make ? hit : '0;
        brk_hit   = is_brk ? hit : '0;
        new_press = make_hit & ~held_q;
        held_d    = (held_q | new_press) & ~brk_hit;
        cmd_d     = new_press | {2'b00, rep_pulse};
        last_d    = (|new_press) ? bus.byte_data : last_q;
    end

    // Auto-repeat for left, right and down.
    for (genvar i = 0; i < 3; i++) begin : g_rpt
        key_repeat_timer #(
            .CW    (CW),
            .DELAY (REPEAT_DELAY),
            .RATE  (REPEAT_RATE)
        ) u_rpt (
            .clk   (Clock),
            .rst   (Reset),
            .start (new_press[i]),
            .stop  (brk_hit[i]),
            .held  (held_q[i]),
            .pulse (rep_pulse[i])
        );
    end

    // Decoder state and registered outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            to_cnt_q <= '0;
            held_q   <= '0;
            cmd_q    <= '0;
            last_q   <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            held_q   <= held_d;
            cmd_q    <= cmd_d;
            last_q   <= last_d;
        end
    end

    assign bus.cmd_left   = cmd_q[K_LEFT];
    assign bus.cmd_right  = cmd_q[K_RIGHT];
    assign bus.cmd_down   = cmd_q[K_DOWN];
    assign bus.cmd_rotate = cmd_q[K_ROT];
    assign bus.cmd_drop   = cmd_q[K_DROP];
    assign bus.key_held   = held_q;
    assign bus.last_code  = last_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed plan plus random byte streams
// checked every cycle against an event-time reference model.
module tb_ps2_key_decoder;

    localparam int DLY = 20;
    localparam int RPT = 5;
    localparam int TO  = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_key_decoder_if bus();

    ps2_key_decoder #(
        .REPEAT_DELAY   (DLY),
        .REPEAT_RATE    (RPT),
        .PREFIX_TIMEOUT (TO),
        .CW             (24)
    ) u_dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @edge %0d: got %0h want %0h",
                      tag, edge_n, got, exp);
    endtask

    // Reference model: absolute edge times of the next repeat.
    longint     edge_n = 0;
    bit         m_held [5];
    longint     m_next [5];
    bit         m_pext, m_pbrk;
    longint     m_plast;
    logic [7:0] m_last;
    logic [4:0] m_cmd;

    function automatic int ref_key(input logic [7:0] b, input bit e);
        if (e) begin
            case (b)
                8'h6B: return 0;
                8'h74: return 1;
                8'h72: return 2;
                8'h75: return 3;
                default: return -1;
            endcase
        end
        case (b)
            8'h22: return 3;
            8'h1A: return 4;
            8'h29: return 4;
            default: return -1;
        endcase
    endfunction

    task automatic model(input bit r, input bit v, input logic [7:0] b);
        int k;
        m_cmd = '0;
        if (r) begin
            foreach (m_held[i]) m_held[i] = 0;
            m_pext = 0;
            m_pbrk = 0;
            m_last = '0;
            return;
        end
        if (v) begin
            if ((m_pext || m_pbrk) && (edge_n - m_plast > TO)) begin
                m_pext = 0;
                m_pbrk = 0;
            end
            if (!m_pbrk && b == 8'hE0) begin
                m_pext  = 1;
                m_plast = edge_n;
            end else if (!m_pbrk && b == 8'hF0) begin
                m_pbrk  = 1;
                m_plast = edge_n;
            end else begin
                k = ref_key(b, m_pext);
                if (k >= 0) begin
                    if (m_pbrk) begin
                        m_held[k] = 0;
                    end else if (!m_held[k]) begin
                        m_held[k] = 1;
                        m_cmd[k]  = 1'b1;
                        m_last    = b;
                        m_next[k] = edge_n + DLY;
                    end
                end
                m_pext = 0;
                m_pbrk = 0;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (m_held[i] && m_next[i] == edge_n) begin
                m_cmd[i]  = 1'b1;
                m_next[i] = m_next[i] + RPT;
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [7:0] b);
        logic [4:0] mh;
        rst            = r;
        bus.byte_valid = v;
        bus.byte_data  = b;
        @(posedge clk);
        edge_n++;
        model(r, v, b);
        #1;
        foreach (m_held[i]) mh[i] = m_held[i];
        chk("cmd", {27'd0, bus.cmd_drop, bus.cmd_rotate, bus.cmd_down,
                    bus.cmd_right, bus.cmd_left}, {27'd0, m_cmd});
        chk("held", {27'd0, bus.key_held}, {27'd0, mh});
        chk("last", {24'd0, bus.last_code}, {24'd0, m_last});
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b0, 1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    logic [7:0] codes [12] = '{8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'h6B, 8'h74,
                               8'h72, 8'h75, 8'h22, 8'h1A, 8'h29, 8'h1C};

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
        idle(2);

        send(8'h1A); idle(3);
        send(8'hF0); send(8'h1A); idle(2);
        send(8'hF0); send(8'h1A); idle(2);
        send(8'h1C); idle(2);

        send(8'hE0); send(8'h6B); idle(3);
        send(8'hE0); send(8'h6B); idle(30);
        for (int i = 0; i < 10 && m_next[0] != edge_n + 3; i++) idle(1);
        chk("align", 32'(m_next[0] - edge_n), 32'd3);
        send(8'hE0); send(8'hF0); send(8'h6B); idle(30);

        send(8'hE0); idle(60); send(8'h6B); idle(5);
        send(8'hE0); idle(10); send(8'h75); idle(3);

        send(8'hE0); send(8'h74); idle(28);
        send(8'hE0); send(8'hF0);
        step(1'b1, 1'b0, 8'h00);
        idle(2);
        send(8'hE0); send(8'hF0); send(8'h74); idle(30);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) step(1'b1, 1'b0, 8'h00);
            send(codes[$urandom_range(0, 11)]);
            if ($urandom_range(0, 7) == 0) idle($urandom_range(55, 70));
            else idle($urandom_range(0, 9));
        end
        idle(40);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
